// File: rtl/ram_fifo_flagged_if.sv
// ram_fifo_flagged_if: producer/consumer bundle for ram_fifo_flagged.
// The FIFO side uses the slave modport; the user side uses the master modport.
interface ram_fifo_flagged_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  shift_in;
    logic [WIDTH-1:0]      wdata;
    logic                  shift_out;
    logic                  clear_err;
    logic [WIDTH-1:0]      rdata;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output shift_in,
        output wdata,
        output shift_out,
        output clear_err,
        input  rdata,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  level,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  shift_in,
        input  wdata,
        input  shift_out,
        input  clear_err,
        output rdata,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output level,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/ram_fifo_flagged.sv
// ram_fifo_flagged: RAM-based synchronous FIFO with level, watermark flags,
// sticky overflow/underflow and a selectable first-word-fall-through read.
module ram_fifo_flagged #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic clk,
    input  logic res_n,
    ram_fifo_flagged_if.slave bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;

    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_THRESH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  full;
    logic                  empty;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  wr_reject;
    logic                  rd_reject;
    logic                  overflow;
    logic                  underflow;

    // The extra wrap bit makes the modular difference cover 0..DEPTH.
    assign level   = wr_ptr - rd_ptr;
    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);

    // A pop frees a slot in the same edge, so a full FIFO still takes a
    // write alongside an accepted read. No bypass exists when empty.
    assign rd_accept = bus.shift_out && !empty;
    assign wr_accept = bus.shift_in && (!full || rd_accept);
    assign wr_reject = bus.shift_in && !wr_accept;
    assign rd_reject = bus.shift_out && empty;

    // Storage array, contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wdata_q();
        end
    end

    function automatic logic [WIDTH-1:0] wdata_q();
        return bus.wdata;
    endfunction

    // Pointer advance on accepted transfers; wraps naturally.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error event beats a clear in the same cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_reject) begin
                overflow <= 1'b1;
            end else if (bus.clear_err) begin
                overflow <= 1'b0;
            end
            if (rd_reject) begin
                underflow <= 1'b1;
            end else if (bus.clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown straight from the array.
            assign bus.rdata = mem[rd_addr];
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;

            // Registered read: load the head word on an accepted pop.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    rdata_q <= '0;
                end else if (rd_accept) begin
                    rdata_q <= mem[rd_addr];
                end
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.level        = level;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level >= AFULL_L);
    assign bus.almost_empty = (level <= AEMPTY_L);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_ram_fifo_flagged.sv
// tb_ram_fifo_flagged: drives FWFT=0 and FWFT=1 instances with identical
// stimulus and checks both against a queue-based reference model.
module tb_ram_fifo_flagged;
    localparam int W     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic         clk = 1'b0;
    logic         res_n = 1'b0;
    logic         shift_in = 1'b0;
    logic         shift_out = 1'b0;
    logic         clear_err = 1'b0;
    logic [W-1:0] wdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_fifo_flagged_if #(.WIDTH(W), .ADDR_WIDTH(AW)) b0 ();
    ram_fifo_flagged_if #(.WIDTH(W), .ADDR_WIDTH(AW)) b1 ();

    assign b0.shift_in  = shift_in;
    assign b0.wdata     = wdata;
    assign b0.shift_out = shift_out;
    assign b0.clear_err = clear_err;
    assign b1.shift_in  = shift_in;
    assign b1.wdata     = wdata;
    assign b1.shift_out = shift_out;
    assign b1.clear_err = clear_err;

    ram_fifo_flagged #(
        .WIDTH(W), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
        .AEMPTY_THRESH(AE), .FWFT(0)
    ) dut0 (
        .clk(clk), .res_n(res_n), .bus(b0)
    );

    ram_fifo_flagged #(
        .WIDTH(W), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
        .AEMPTY_THRESH(AE), .FWFT(1)
    ) dut1 (
        .clk(clk), .res_n(res_n), .bus(b1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of words.
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    bit           m_ovf = 0;
    bit           m_unf = 0;
    logic [W-1:0] m_last = '0;

    initial begin : model
        bit rd, wr, eo, eu;
        forever begin
            @(posedge clk or negedge res_n);
            if (!res_n) begin
                mq.delete();
                exp_q.delete();
                m_ovf  = 0;
                m_unf  = 0;
                m_last = '0;
            end else begin
                rd = shift_out && (mq.size() > 0);
                wr = shift_in && ((mq.size() < DEPTH) || rd);
                eo = shift_in && !wr;
                eu = shift_out && (mq.size() == 0);
                if (rd) begin
                    m_last = mq.pop_front();
                    exp_q.push_back(m_last);
                end
                if (wr) mq.push_back(wdata);
                m_ovf = eo || (m_ovf && !clear_err);
                m_unf = eu || (m_unf && !clear_err);
            end
        end
    end

    // Scoreboard monitor for the registered-read instance.
    initial begin : monitor
        bit           fire;
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            fire = res_n && shift_out && !b0.empty;
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata_std", b0.rdata, e);
                end
            end
        end
    end

    task automatic chk_flags(input string tag, input logic [AW:0] lv,
                             input logic f, input logic e, input logic af,
                             input logic ae, input logic ov, input logic un);
        int n;
        n = mq.size();
        check({tag, "_level"}, lv, n);
        check({tag, "_full"}, f, n == DEPTH);
        check({tag, "_empty"}, e, n == 0);
        check({tag, "_afull"}, af, n >= AF);
        check({tag, "_aempty"}, ae, n <= AE);
        check({tag, "_overflow"}, ov, m_ovf);
        check({tag, "_underflow"}, un, m_unf);
    endtask

    // Per-cycle state checks away from the active edge.
    initial begin : flagchk
        forever begin
            @(negedge clk);
            if (res_n) begin
                chk_flags("std", b0.level, b0.full, b0.empty,
                          b0.almost_full, b0.almost_empty,
                          b0.overflow, b0.underflow);
                chk_flags("fwft", b1.level, b1.full, b1.empty,
                          b1.almost_full, b1.almost_empty,
                          b1.overflow, b1.underflow);
                check("rdata_hold", b0.rdata, m_last);
                if (mq.size() > 0) check("rdata_fwft", b1.rdata, mq[0]);
            end
        end
    end

    task automatic step(input logic si, input logic [W-1:0] d,
                        input logic so, input logic ce);
        @(negedge clk);
        shift_in  = si;
        wdata     = d;
        shift_out = so;
        clear_err = ce;
    endtask

    initial begin : stim
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        res_n = 1'b1;
        step(0, 8'h00, 0, 0);
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(1, 8'h55, 0, 0);
        step(0, 8'h00, 0, 1);
        repeat (4) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'hA5, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 1);
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(1, 8'h66, 1, 0);
        repeat (4) step(0, 8'h00, 1, 0);
        step(1, 8'h80, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h81 + i), 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 5));
        end
        repeat (DEPTH + 1) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'h88, 0, 0);
        @(posedge clk);
        #2;
        res_n = 1'b0;
        #1;
        check("rst_empty_std", b0.empty, 1);
        check("rst_level_std", b0.level, 0);
        check("rst_empty_fwft", b1.empty, 1);
        check("rst_level_fwft", b1.level, 0);
        check("rst_rdata_std", b0.rdata, 0);
        @(negedge clk);
        res_n = 1'b1;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_fifo_flagged.md
# ram_fifo_flagged

Parametrised, single-clock, RAM-based synchronous FIFO with full usable depth, fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It is the general-purpose buffering block between producer/consumer stages in the datapath. The team uses it wherever a plain FIFO needs flow-control watermarks or error reporting.

## Interface
- WIDTH, 8, data word width in bits
- ADDR_WIDTH, 4, address bits; depth DEPTH = 2**ADDR_WIDTH entries, all usable
- AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full asserted when level >= AFULL_THRESH
- AEMPTY_THRESH, 1, almost_empty asserted when level <= AEMPTY_THRESH
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  input  1  single clock, all logic on rising edge
- res_n  input  1  asynchronous, active-low reset
- shift_in  input  1  write request
- wdata  input  WIDTH  write data, sampled with shift_in
- shift_out  input  1  read/pop request
- rdata  output  WIDTH  read data
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- almost_full  output  1  level >= AFULL_THRESH
- almost_empty  output  1  level <= AEMPTY_THRESH
- level  output  ADDR_WIDTH+1  current number of stored words, 0..DEPTH
- overflow  output  1  sticky: write attempted while full and not accepted
- underflow  output  1  sticky: read attempted while empty
- clear_err  input  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH x WIDTH array, no reset on contents. Write pointer wr_ptr and read pointer rd_ptr are ADDR_WIDTH+1 bits wide (extra wrap bit); the address is the low ADDR_WIDTH bits.
- level = wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1); full/empty/almost flags are all combinational decodes of level.
- Write accepted: shift_in && (!full || rd_accept). Stores wdata at wr_ptr; wr_ptr increments; wraps naturally.
- Read accepted (rd_accept): shift_out && !empty. rd_ptr increments.
- Simultaneous accepted read and write: level unchanged. When full, the write is accepted because the pop frees the slot; the popped word is the old contents (read-before-write at the same address).
- Empty with shift_in && shift_out: write accepted, read rejected, underflow set. There is no bypass path.
- Rejected write (shift_in && full && !rd_accept): no state change, overflow <= 1.
- Rejected read (shift_out && empty): no state change, underflow <= 1.
- clear_err clears both sticky flags. When an error event coincides with clear_err, set wins.
- FWFT=0: on an accepted read, rdata <= mem[rd_ptr] at the clock edge. Otherwise rdata holds its value.
- FWFT=1: rdata = mem[rd_ptr] combinationally (asynchronous RAM read); it is valid whenever empty==0. shift_out pops the displayed word.

## Timing
- Reset (res_n low, async): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_THRESH>0), overflow=underflow=0, rdata=0 in FWFT=0. Reset mid-operation discards all contents immediately.
- Write latency: the word written at edge N makes empty=0 and updates level after edge N. In FWFT=1 the word appears on rdata in that same cycle.
- Read latency, FWFT=0: shift_out sampled at edge N gives data on rdata after edge N (1 cycle).
- Read latency, FWFT=1: 0 cycles. The next word is shown after the popping edge.
- Flags update in the cycle following the causing edge. No flag depends combinationally on shift_in or shift_out.
- Throughput: 1 write and 1 read per cycle sustained, including across pointer wrap.

## Test plan
(Bench parameters: WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1.)
- Reset then write 0x11,0x22,0x33,0x44 on consecutive cycles -> level 1,2,3,4; almost_empty drops at level 2; almost_full at 3; full at 4; overflow=0.
- Full FIFO, write 0x55 alone -> rejected, level stays 4, overflow=1. Then clear_err -> overflow=0. Then read 4 words (FWFT=0) -> rdata 0x11,0x22,0x33,0x44, each 1 cycle after its shift_out; empty=1 at the end.
- Empty FIFO, shift_in=shift_out=1 with 0xA5 -> level 1, underflow=1, rdata unchanged. The next read returns 0xA5.
- Full FIFO, simultaneous write 0x66 and read -> level stays 4, rdata=0x11. Draining yields 0x22,0x33,0x44,0x66.
- 20 cycles of concurrent write/read with incrementing data (pointer wraps several times) -> level constant, data in order, no error flags.
- FWFT=1: write 0x77 -> next cycle empty=0 and rdata=0x77 without shift_out. Assert res_n low mid-stream -> empty=1, level=0 immediately.
